// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : mc_pkg                                                    |
// | Purpose  : Shared encodings for the multicycle control unit: state   |
// |            codes, opcodes, ALU codes, PC-source and dest selects,    |
// |            decoded instruction-class bundle and R-type ALU lookup.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b101
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b010;
  localparam logic [2:0] ALUC_SLL = 3'b100;
  localparam logic [2:0] ALUC_OR  = 3'b101;
  localparam logic [2:0] ALUC_AND = 3'b110;

  localparam logic [1:0] PCSRC_PC4 = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_REG = 2'd2;
  localparam logic [1:0] PCSRC_JMP = 2'd3;

  localparam logic [1:0] REGRT_R31 = 2'd0;
  localparam logic [1:0] REGRT_RT  = 2'd1;
  localparam logic [1:0] REGRT_RD  = 2'd2;

  // One bit per instruction class; at most one is set for a legal opcode.
  typedef struct packed {
    logic rtype;
    logic addi;
    logic ori;
    logic sll;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jr;
    logic jal;
    logic halt;
  } iclass_t;

  // ALU operation for register-register instructions; move is an add.
  function automatic logic [2:0] rtype_aluc(input logic [5:0] op6);
    logic [2:0] code;
    code = ALUC_ADD;
    case (op6)
      OP_SUB:  code = ALUC_SUB;
      OP_OR:   code = ALUC_OR;
      OP_AND:  code = ALUC_AND;
      OP_SLT:  code = ALUC_SLT;
      default: code = ALUC_ADD;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc_decode                                                 |
// | Purpose  : Combinational opcode decoder: maps the opcode onto a      |
// |            one-hot instruction class and flags undefined opcodes.    |
// |            Non-zero bits above bit 5 make the opcode undefined.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mc_decode
  import mc_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output iclass_t         iclass,
  output logic            illegal
);

  logic       upper_nz;
  logic       known;
  logic [5:0] op6;

  assign op6 = op[5:0];

  generate
    if (OP_W > 6) begin : g_wide_op
      assign upper_nz = |op[OP_W-1:6];
    end else begin : g_narrow_op
      assign upper_nz = 1'b0;
    end
  endgenerate

  // Opcode to instruction class; anything unmatched is illegal.
  always_comb begin
    iclass = '0;
    known  = 1'b1;
    case (op6)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_MOVE, OP_SLT: iclass.rtype = 1'b1;
      OP_ADDI: iclass.addi = 1'b1;
      OP_ORI:  iclass.ori  = 1'b1;
      OP_SLL:  iclass.sll  = 1'b1;
      OP_LW:   iclass.lw   = 1'b1;
      OP_SW:   iclass.sw   = 1'b1;
      OP_BEQ:  iclass.beq  = 1'b1;
      OP_J:    iclass.j    = 1'b1;
      OP_JR:   iclass.jr   = 1'b1;
      OP_JAL:  iclass.jal  = 1'b1;
      OP_HALT: iclass.halt = 1'b1;
      default: known = 1'b0;
    endcase
    if (upper_nz) begin
      iclass = '0;
      known  = 1'b0;
    end
    illegal = ~known;
  end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mc_ctrl                                                   |
// | Purpose  : Multicycle CPU control unit. Sequences IF/ID/EXE/MEM/WB   |
// |            with ready/valid memory handshakes, sticky HALT and       |
// |            illegal-opcode trap. Control outputs are decoded from the |
// |            current state and opcode in the same cycle and forced to  |
// |            their defaults while resetn is low.                       |
// | Config   : MC_CTRL_INSTRET_EN enables the retired-instruction        |
// |            counter; without it instret is tied to zero.              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [OP_W-1:0]   op,
  input  logic              z,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic              imem_req,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              wpc,
  output logic              wir,
  output logic              wreg,
  output logic [1:0]        regrt,
  output logic              m2reg,
  output logic              wrregdata,
  output logic [ALUC_W-1:0] aluc,
  output logic              alusrcb,
  output logic [1:0]        pcsource,
  output logic              sext,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  instret
);

  state_t     cur_state;
  iclass_t    cls;
  logic       op_illegal;
  logic       halted_q;
  logic       illegal_q;
  logic [2:0] alu_sel;

  mc_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .op      (op),
    .iclass  (cls),
    .illegal (op_illegal)
  );

  // Sequencer state and sticky halt/trap flags.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cur_state <= ST_IF;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (cur_state)
        ST_IF: begin
          if (imem_ready) cur_state <= ST_ID;
        end
        ST_ID: begin
          if (op_illegal) begin
            cur_state <= ST_HALT;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end else if (cls.halt) begin
            cur_state <= ST_HALT;
            halted_q  <= 1'b1;
          end else if (cls.j || cls.jr || cls.jal) begin
            cur_state <= ST_IF;
          end else begin
            cur_state <= ST_EXE;
          end
        end
        ST_EXE: begin
          if (cls.beq)               cur_state <= ST_IF;
          else if (cls.lw || cls.sw) cur_state <= ST_MEM;
          else                       cur_state <= ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) cur_state <= cls.sw ? ST_IF : ST_WB;
        end
        ST_WB:   cur_state <= ST_IF;
        ST_HALT: cur_state <= ST_HALT;
        default: cur_state <= ST_IF;
      endcase
    end
  end

  // Datapath controls for the current state; all defaults while in reset.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    wpc       = 1'b0;
    wir       = 1'b0;
    wreg      = 1'b0;
    regrt     = REGRT_R31;
    m2reg     = 1'b0;
    wrregdata = 1'b0;
    alu_sel   = ALUC_ADD;
    alusrcb   = 1'b0;
    pcsource  = PCSRC_PC4;
    sext      = 1'b1;
    if (resetn) begin
      case (cur_state)
        ST_IF: begin
          imem_req = 1'b1;
          wir      = imem_ready;
        end
        ST_ID: begin
          if (cls.j) begin
            wpc      = 1'b1;
            pcsource = PCSRC_JMP;
          end else if (cls.jal) begin
            wpc       = 1'b1;
            pcsource  = PCSRC_JMP;
            wreg      = 1'b1;
            regrt     = REGRT_R31;
            wrregdata = 1'b0;
          end else if (cls.jr) begin
            wpc      = 1'b1;
            pcsource = PCSRC_REG;
          end
        end
        ST_EXE: begin
          if (cls.rtype) begin
            alu_sel = rtype_aluc(op[5:0]);
          end else if (cls.sll) begin
            alusrcb = 1'b1;
            alu_sel = ALUC_SLL;
          end else if (cls.addi) begin
            alusrcb = 1'b1;
          end else if (cls.ori) begin
            alusrcb = 1'b1;
            sext    = 1'b0;
            alu_sel = ALUC_OR;
          end else if (cls.beq) begin
            alu_sel  = ALUC_SUB;
            wpc      = 1'b1;
            pcsource = z ? PCSRC_BR : PCSRC_PC4;
          end else if (cls.lw || cls.sw) begin
            alusrcb = 1'b1;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = cls.sw;
          wpc      = dmem_ready && cls.sw;
        end
        ST_WB: begin
          wreg      = 1'b1;
          wpc       = 1'b1;
          wrregdata = 1'b1;
          if (cls.lw) begin
            m2reg = 1'b1;
            regrt = REGRT_RT;
          end else if (cls.addi || cls.ori || cls.sll) begin
            regrt = REGRT_RT;
          end else begin
            regrt = REGRT_RD;
          end
        end
        default: ;
      endcase
    end
  end

  assign aluc    = ALUC_W'(alu_sel);
  assign state   = cur_state;
  assign halted  = halted_q;
  assign illegal = illegal_q;

`ifdef MC_CTRL_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  // Every PC write returns to IF, so each one retires an instruction.
  always_ff @(posedge clock) begin
    if (!resetn)  instret_q <= '0;
    else if (wpc) instret_q <= instret_q + CNT_W'(1);
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mc_ctrl                                                |
// | Purpose  : Directed self-checking bench for mc_ctrl. Each cycle the  |
// |            full control bundle is compared with a hand-written       |
// |            vector; flags and instret are checked at key points.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_mc_ctrl;

`ifdef MC_CTRL_INSTRET_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic [5:0]  op;
  logic        z;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, dmem_req, dmem_we, wpc, wir, wreg, m2reg, wrregdata;
  logic        alusrcb, sext, halted, illegal;
  logic [1:0]  regrt, pcsource;
  logic [2:0]  aluc, state;
  logic [31:0] instret;
  logic [19:0] obs;

  int checks   = 0;
  int failures = 0;

  mc_ctrl u_dut (
    .clock      (clock),
    .resetn     (resetn),
    .op         (op),
    .z          (z),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .wpc        (wpc),
    .wir        (wir),
    .wreg       (wreg),
    .regrt      (regrt),
    .m2reg      (m2reg),
    .wrregdata  (wrregdata),
    .aluc       (aluc),
    .alusrcb    (alusrcb),
    .pcsource   (pcsource),
    .sext       (sext),
    .state      (state),
    .halted     (halted),
    .illegal    (illegal),
    .instret    (instret)
  );

  always #5 clock = ~clock;

  assign obs = {imem_req, dmem_req, dmem_we, wpc, wir, wreg, regrt, m2reg,
                wrregdata, aluc, alusrcb, pcsource, sext, state};

  // Pack an expected control bundle in the same order as obs.
  function automatic logic [19:0] ctl(
    input logic ireq, input logic dreq, input logic we, input logic pcw,
    input logic irw, input logic rw, input logic [1:0] rt, input logic m2r,
    input logic wrd, input logic [2:0] alu, input logic srcb,
    input logic [1:0] pcs, input logic sx, input logic [2:0] st);
    return {ireq, dreq, we, pcw, irw, rw, rt, m2r, wrd, alu, srcb, pcs, sx, st};
  endfunction

  function automatic logic [19:0] dflt(input logic [2:0] st);
    return ctl(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 2'd0, 1, st);
  endfunction

  function automatic logic [31:0] ret(input int n);
    return CNT_ON ? n : 0;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for this cycle, compare the bundle, advance one clock.
  task automatic cyc(input logic ir, input logic dr, input logic zz,
                     input string tag, input logic [19:0] exp);
    imem_ready = ir;
    dmem_ready = dr;
    z          = zz;
    #1;
    check_eq(tag, 64'(obs), 64'(exp));
    @(posedge clock);
    #1;
  endtask

  localparam logic [19:0] IF_WAIT = 20'b1_0_0_0_0_0_00_0_0_000_0_00_1_000;
  localparam logic [19:0] IF_RDY  = 20'b1_0_0_0_1_0_00_0_0_000_0_00_1_000;

  initial begin
    resetn = 1'b0; op = 6'b111000; z = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    @(posedge clock); #1;
    // Reset held: outputs at defaults even with j opcode and ready high.
    cyc(1, 1, 0, "rst_outputs", dflt(3'd0));
    check_eq("rst_halted", 64'(halted), 64'd0);
    check_eq("rst_illegal", 64'(illegal), 64'd0);
    check_eq("rst_instret", 64'(instret), 64'd0);
    resetn = 1'b1;

    // add, zero-wait
    op = 6'b000000;
    cyc(1, 1, 0, "add_if", IF_RDY);
    cyc(1, 1, 0, "add_id", dflt(3'd1));
    cyc(0, 1, 0, "add_exe", dflt(3'd2));
    check_eq("add_ret_before", 64'(instret), 64'(ret(0)));
    cyc(0, 0, 0, "add_wb", ctl(0, 0, 0, 1, 0, 1, 2'd2, 0, 1, 3'd0, 0, 2'd0, 1, 3'd4));
    check_eq("add_ret_after", 64'(instret), 64'(ret(1)));

    // lw with 2 imem wait cycles and 3 dmem wait cycles
    op = 6'b110001;
    cyc(0, 0, 0, "lw_if0", IF_WAIT);
    cyc(0, 0, 0, "lw_if1", IF_WAIT);
    cyc(1, 0, 0, "lw_if2", IF_RDY);
    cyc(0, 0, 0, "lw_id", dflt(3'd1));
    cyc(0, 0, 0, "lw_exe", ctl(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 1, 2'd0, 1, 3'd2));
    for (int i = 0; i < 4; i++)
      cyc(0, (i == 3), 0, $sformatf("lw_mem%0d", i),
          ctl(0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 2'd0, 1, 3'd3));
    cyc(0, 0, 0, "lw_wb", ctl(0, 0, 0, 1, 0, 1, 2'd1, 1, 1, 3'd0, 0, 2'd0, 1, 3'd4));
    check_eq("lw_ret", 64'(instret), 64'(ret(2)));

    // beq taken then not taken
    op = 6'b110100;
    cyc(1, 0, 0, "beq1_if", IF_RDY);
    cyc(0, 0, 1, "beq1_id", dflt(3'd1));
    cyc(0, 0, 1, "beq1_exe", ctl(0, 0, 0, 1, 0, 0, 2'd0, 0, 0, 3'd1, 0, 2'd1, 1, 3'd2));
    cyc(1, 0, 0, "beq0_if", IF_RDY);
    cyc(0, 0, 0, "beq0_id", dflt(3'd1));
    cyc(0, 0, 0, "beq0_exe", ctl(0, 0, 0, 1, 0, 0, 2'd0, 0, 0, 3'd1, 0, 2'd0, 1, 3'd2));
    check_eq("beq_ret", 64'(instret), 64'(ret(4)));

    // jal then jr
    op = 6'b111010;
    cyc(1, 0, 0, "jal_if", IF_RDY);
    cyc(0, 0, 0, "jal_id", ctl(0, 0, 0, 1, 0, 1, 2'd0, 0, 0, 3'd0, 0, 2'd3, 1, 3'd1));
    op = 6'b111001;
    cyc(1, 0, 0, "jr_if", IF_RDY);
    cyc(0, 0, 0, "jr_id", ctl(0, 0, 0, 1, 0, 0, 2'd0, 0, 0, 3'd0, 0, 2'd2, 1, 3'd1));
    check_eq("jump_ret", 64'(instret), 64'(ret(6)));

    // ori: zero-extended immediate, or
    op = 6'b010010;
    cyc(1, 0, 0, "ori_if", IF_RDY);
    cyc(0, 0, 0, "ori_id", dflt(3'd1));
    cyc(0, 0, 0, "ori_exe", ctl(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd5, 1, 2'd0, 0, 3'd2));
    cyc(0, 0, 0, "ori_wb", ctl(0, 0, 0, 1, 0, 1, 2'd1, 0, 1, 3'd0, 0, 2'd0, 1, 3'd4));
    check_eq("ori_ret", 64'(instret), 64'(ret(7)));

    // sw aborted by reset during the MEM wait
    op = 6'b110000;
    cyc(1, 0, 0, "sw_if", IF_RDY);
    cyc(0, 0, 0, "sw_id", dflt(3'd1));
    cyc(0, 0, 0, "sw_exe", ctl(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 3'd0, 1, 2'd0, 1, 3'd2));
    cyc(0, 0, 0, "sw_mem0", ctl(0, 1, 1, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 2'd0, 1, 3'd3));
    cyc(0, 0, 0, "sw_mem1", ctl(0, 1, 1, 0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 2'd0, 1, 3'd3));
    resetn = 1'b0;
    #1;
    check_eq("sw_rst_ret", 64'(instret), 64'(ret(7)));
    cyc(0, 1, 0, "sw_rst", dflt(3'd3));
    resetn = 1'b1;
    cyc(0, 0, 0, "sw_after", IF_WAIT);
    check_eq("sw_after_ret", 64'(instret), 64'd0);

    // illegal opcode traps into HALT
    op = 6'b000011;
    cyc(1, 0, 0, "ill_if", IF_RDY);
    check_eq("ill_id_halted", 64'(halted), 64'd0);
    cyc(0, 0, 0, "ill_id", dflt(3'd1));
    check_eq("ill_halted", 64'(halted), 64'd1);
    check_eq("ill_illegal", 64'(illegal), 64'd1);
    cyc(1, 1, 0, "ill_halt0", dflt(3'd5));
    cyc(1, 1, 0, "ill_halt1", dflt(3'd5));
    check_eq("ill_ret", 64'(instret), 64'd0);
    resetn = 1'b0;
    cyc(1, 1, 0, "ill_rst", dflt(3'd5));
    resetn = 1'b1;
    check_eq("ill_clr_halted", 64'(halted), 64'd0);
    check_eq("ill_clr_illegal", 64'(illegal), 64'd0);
    cyc(0, 0, 0, "ill_post", IF_WAIT);

    // halt opcode: halted without illegal
    op = 6'b111111;
    cyc(1, 0, 0, "halt_if", IF_RDY);
    cyc(0, 0, 0, "halt_id", dflt(3'd1));
    check_eq("halt_halted", 64'(halted), 64'd1);
    check_eq("halt_illegal", 64'(illegal), 64'd0);
    cyc(1, 0, 0, "halt_stay", dflt(3'd5));
    check_eq("halt_ret", 64'(instret), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Parametrised multicycle CPU control unit: the next-generation sequencer for the multicycle datapath. It decodes the 6-bit opcode of the team ISA and steps through IF/ID/EXE/MEM/WB, driving every datapath write-enable and mux select. Over the previous controller it adds ready/valid memory handshakes (variable-latency instruction and data memories), a sticky HALT state, illegal-opcode trapping, and an optional retired-instruction counter.

## Interface
- OP_W, 6: opcode width; opcode compares use the low 6 bits, upper bits must be zero.
- ALUC_W, 3: ALU control width.
- CNT_W, 32: instret counter width.

- clock  in  1  clock; all state changes on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- op  in  OP_W  opcode field of IR.
- z  in  1  ALU zero flag.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write (valid with dmem_req).
- wpc  out  1  PC write enable.
- wir  out  1  IR write enable.
- wreg  out  1  register file write enable.
- regrt  out  2  dest select: 0 r31 (jal), 1 rt, 2 rd.
- m2reg  out  1  write-back data from memory.
- wrregdata  out  1  write-back from ALU/memory (0 = PC+4 link).
- aluc  out  ALUC_W  000 add, 001 sub, 010 slt, 100 sll, 101 or, 110 and.
- alusrcb  out  1  ALU B: 0 register, 1 immediate.
- pcsource  out  2  0 PC+4, 1 branch target, 2 register (jr), 3 jump target.
- sext  out  1  1 sign-extend, 0 zero-extend immediate.
- state  out  3  current state encoding.
- halted  out  1  sticky, HALT reached.
- illegal  out  1  sticky, halt caused by undefined opcode.
- instret  out  CNT_W  retired instructions (macro-dependent).

## Operation
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, move 100000, slt 100111, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111; others illegal.
- States: IF 000, ID 001, EXE 010, MEM 011, WB 100, HALT 101.
- Defaults every cycle: all enables/requests 0, aluc 000, alusrcb 0, regrt 0, m2reg 0, wrregdata 0, pcsource 0, sext 1.
- IF: imem_req=1; hold until imem_ready; on ready wir=1, -> ID.
- ID: j: wpc=1, pcsource=3 -> IF. jal: additionally wreg=1, regrt=0, wrregdata=0. jr: wpc=1, pcsource=2 -> IF. halt: -> HALT, halted<=1. illegal: -> HALT, halted<=1, illegal<=1. Others -> EXE.
- EXE: R-type alusrcb=0, aluc per op (move = add) -> WB. sll: alusrcb=1, aluc=100 -> WB. addi: alusrcb=1, sext=1, add -> WB. ori: alusrcb=1, sext=0, or -> WB. beq: aluc=001, wpc=1, pcsource = z ? 1 : 0 -> IF. lw/sw: alusrcb=1, add -> MEM.
- MEM: dmem_req=1, dmem_we = sw; hold until dmem_ready. sw on ready: wpc=1 -> IF. lw on ready: -> WB.
- WB: wreg=1, wpc=1, wrregdata=1 -> IF; lw: m2reg=1, regrt=1; addi/ori/sll regrt=1; R-type regrt=2.
- HALT: all enables 0; exit only by reset.
- Retire event = wpc=1 in a state transitioning to IF.

## Timing
- Reset: state<=IF, halted<=0, illegal<=0, instret<=0; while resetn is low all outputs are forced to defaults (imem_req=0), independent of op.
- Zero-wait latencies: j/jr/jal 2 cycles, beq 3, R/I-type 4, sw 4, lw 5; each ready-low cycle adds one.
- Requests stay asserted, and their outputs stable, until the ready cycle; ready sampled only while the request is high; ready with no request is ignored.
- Reset mid-wait (IF/MEM) aborts the access: next cycle IF with requests low.
- op must be stable from the ID cycle to the retire event.
- instret wraps modulo 2^CNT_W.

## Configuration
- MC_CTRL_INSTRET_EN defined: instret increments by 1 per retire event (not on halt/illegal).
- Undefined: counter absent, instret tied to 0.

## Structure
- Package mc_pkg: state encodings, opcode constants, aluc codes, pcsource/regrt codes.
- Sub-module mc_decode: combinational op -> one-hot instruction class plus illegal flag; mc_ctrl holds FSM, sticky flags, and counter.

## Test plan
- add, imem_ready tied 1: states IF,ID,EXE,WB; WB has wreg=1, regrt=2, wpc=1; instret 0->1.
- lw, imem_ready low 2 cycles, dmem_ready low 3 cycles: total 10 cycles; dmem_req high 4 cycles with dmem_we=0; WB m2reg=1, regrt=1.
- beq z=1 then z=0: EXE pcsource=1 then 0, wpc=1 both, 3 cycles each.
- jal: ID wpc=1, pcsource=3, wreg=1, regrt=0, wrregdata=0; next state IF.
- op=000011: HALT, halted=1, illegal=1; imem_ready pulses cause no transition; resetn low one cycle -> IF, flags cleared.
- resetn low during MEM wait of sw: next cycle IF, dmem_req=0, no wpc pulse, instret unchanged.
